// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Drives the 4-digit packed-BCD bus of the seven-segment scanner; the result
// register only changes when a conversion completes.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   start     conversion request, sampled only while idle
//   bin       unsigned binary input, latched when start is accepted
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when nums/overflow are updated
//   overflow  last accepted bin exceeded MAX_VAL
//   nums      packed BCD result, digit 0 in [3:0] .. digit 3 in [15:12]
//
// Optional build macro: BIN2BCD_LZ_BLANK_EN
//   When defined, leading zero digits 3..1 are replaced by 4'hF on load.
module bin2bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [15:0]      nums
);

  localparam int          CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_U = 32'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] sreg_q, sreg_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      nums_q, nums_d;
  logic             bin_ovf;

  function automatic logic [3:0] adj_digit(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

`ifdef BIN2BCD_LZ_BLANK_EN
  // Blank digits 3..1 while every digit above is zero; digit 0 always shown.
  function automatic logic [15:0] lz_blank(input logic [15:0] v);
    logic [15:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      if (lead && (r[4*(3-k) +: 4] == 4'h0)) begin
        r[4*(3-k) +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction
`endif

  always_comb begin
    bin_ovf = 32'(bin) > MAX_U;
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    nums_d     = nums_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          sreg_d     = bin;
          scratch_d  = '0;
          ovf_flag_d = bin_ovf;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
          // Out-of-range input takes a single throwaway shift so completion
          // lands two edges after accept; the scratch value is discarded.
          cnt_d      = bin_ovf ? CNT_W'(1) : CNT_W'(BIN_W);
        end
      end
      ST_SHIFT: begin
        // Adjust all digits in parallel, then shift {scratch, sreg} left by one.
        scratch_d = {3'(adj_digit(scratch_q[15:12])),
                     adj_digit(scratch_q[11:8]),
                     adj_digit(scratch_q[7:4]),
                     adj_digit(scratch_q[3:0]),
                     sreg_q[BIN_W-1]};
        sreg_d    = {sreg_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef BIN2BCD_LZ_BLANK_EN
        nums_d = ovf_flag_q ? 16'hFFFF : lz_blank(scratch_q);
`else
        nums_d = ovf_flag_q ? 16'hFFFF : scratch_q;
`endif
        overflow_d = ovf_flag_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      nums_q     <= '0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      nums_q     <= nums_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign nums     = nums_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed scenarios plus randomized conversions,
// resets and ignored start pulses, checked by a scoreboard against a
// decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int BIN_W   = 14;
  localparam int MAX_VAL = 9999;
  localparam int LAT     = BIN_W + 1;
  localparam int BND [10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin   = '0;
  logic             busy, done, overflow;
  logic [15:0]      nums;

  always #5 clk = ~clk;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .MAX_VAL(MAX_VAL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
    .nums    (nums)
  );

  typedef struct {
    logic [15:0] nums;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        new_e, cur_e;
  int          cyc       = 0;
  int          next_free = 0;
  int          last_acc  = -1;
  int          new_v;
  bit          armed     = 1'b0;
  bit          rst_edge  = 1'b0;
  bit          exp_done, exp_busy;
  int          n_checks  = 0;
  int          n_err     = 0;
  logic [15:0] mdl_nums  = '0;
  logic        mdl_ovf   = 1'b0;

  // Reference: decimal digits by division, blanking by magnitude.
  function automatic logic [15:0] ref_nums(input int v);
    logic [15:0] r;
    if (v > MAX_VAL) return 16'hFFFF;
    r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`ifdef BIN2BCD_LZ_BLANK_EN
    if (v < 1000) r[15:12] = 4'hF;
    if (v < 100)  r[11:8]  = 4'hF;
    if (v < 10)   r[7:4]   = 4'hF;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Stimulus side of the model: decides acceptance and pushes expectations.
  always @(posedge clk) begin
    cyc++;
    rst_edge = rst;
    if (rst) begin
      armed = 1'b1;
      sb.delete();
      next_free = cyc + 1;
    end else if (start && cyc >= next_free) begin
      new_v     = int'(bin);
      new_e.nums = ref_nums(new_v);
      new_e.ovf  = new_v > MAX_VAL;
      new_e.due  = cyc + (new_e.ovf ? 2 : LAT);
      sb.push_back(new_e);
      next_free = new_e.due + 1;
      last_acc  = cyc;
    end
  end

  // Monitor: checks handshake every cycle, pops on completion.
  always @(negedge clk) begin
    if (armed) begin
      if (rst_edge) begin
        mdl_nums = '0;
        mdl_ovf  = 1'b0;
      end
      exp_done = (sb.size() > 0) && (sb[0].due == cyc);
      exp_busy = (sb.size() > 0) && (cyc < sb[0].due);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      if ((done === 1'b1 || exp_done) && sb.size() > 0) begin
        cur_e    = sb.pop_front();
        mdl_nums = cur_e.nums;
        mdl_ovf  = cur_e.ovf;
      end
      chk("nums", 32'(nums), 32'(mdl_nums));
      chk("overflow", 32'(overflow), 32'(mdl_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_acc();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (last_acc == cyc) return;
    end
    n_checks++;
    n_err++;
    $display("FAIL accept_timeout: got none expected accept at cycle %0d", cyc);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && cyc + 1 >= next_free) return;
    end
    n_checks++;
    n_err++;
    $display("FAIL idle_timeout: got %0d pending expected 0 at cycle %0d", sb.size(), cyc);
  endtask

  task automatic convert(input int v);
    bin   = BIN_W'(v);
    start = 1'b1;
    wait_acc();
    start = 1'b0;
  endtask

  initial begin
    int v;
    int r;
    tick(3);
    rst = 1'b0;
    tick(2);

    convert(39);
    wait_idle();

    // Back-to-back with start held high.
    bin   = BIN_W'(9999);
    start = 1'b1;
    wait_acc();
    bin = BIN_W'(0);
    wait_acc();
    bin = BIN_W'(1000);
    wait_acc();
    start = 1'b0;
    wait_idle();

    convert(10000);
    wait_idle();
    convert(5);
    wait_idle();
    convert(205);
    wait_idle();

    // Start while busy must be ignored.
    convert(1234);
    tick(4);
    bin   = BIN_W'(42);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle();

    // Reset mid-conversion aborts without a done pulse.
    convert(7777);
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    convert(12);
    wait_idle();

    // Reset and start on the same edge: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    bin   = BIN_W'(77);
    tick(1);
    rst   = 1'b0;
    start = 1'b0;
    tick(2);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) v = BND[$urandom_range(0, 9)];
      else v = int'($urandom_range(0, (1 << BIN_W) - 1));
      convert(v);
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        tick(int'($urandom_range(0, 16)));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end else if (r == 1) begin
        tick(int'($urandom_range(0, 12)));
        bin   = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end else if (r == 2) begin
        bin   = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
        start = 1'b1;
        wait_acc();
        start = 1'b0;
      end
      wait_idle();
    end

    wait_idle();
    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
- Sits directly upstream of the 4-digit seven-segment scanner and drives its 16-bit packed-BCD digit bus.
  - Digit 0 (ones) is in [3:0]; digit 3 (thousands) is in [15:12].
- Result register holds its value between conversions, so the display never shows intermediate values.

Parameters:
- BIN_W, 14: width of the binary input. Sets the shift count; must be ≤ 14.
- MAX_VAL, 9999: largest convertible value. Anything above it is reported as overflow.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request. Sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value. Latched on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/overflow are updated.
- overflow  output  1  last accepted bin was > MAX_VAL. Held until the next completion.
- nums  output  16  packed BCD result, 4 digits. Feeds the display scanner.

Behaviour:
- Clock and reset:
  - One clock, clk; all state updates on its rising edge.
  - Reset is synchronous and active-high on rst.
  - Reset values: nums=16'h0000, busy=0, done=0, overflow=0, state=IDLE, shift count=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: latch bin into the shift register, clear the BCD scratch, load count=BIN_W, set busy=1.
  - If bin > MAX_VAL → go to DONE. Otherwise → go to SHIFT.
- SHIFT, one bit per edge:
  - For each scratch digit ≥ 5, add 3 (all 4 digits adjusted in parallel).
  - Then shift {scratch, shiftreg} left by 1 and decrement count.
  - When count reaches 0 after the shift → go to DONE.
  - Scratch adds are 4-bit; inputs ≤ 9999 cannot carry out of a digit.
- DONE, one cycle:
  - On the edge leaving DONE: nums ← scratch (or 16'hFFFF on overflow), overflow ← overflow flag, done=1 for exactly one cycle, busy ← 0, state → IDLE.
- Latency:
  - Start accepted at edge N → nums/done update at edge N+BIN_W+1 (15 cycles for the default).
  - Overflow path: done at edge N+2.
- Outputs during conversion:
  - nums and overflow hold their previous values the whole time busy=1; they change only together with done.
- Start handling:
  - start while busy=1 is ignored; nothing is queued.
  - start held high continuously → back-to-back conversions, because IDLE re-samples start on the cycle after done.
  - The edge that asserts done returns to IDLE; the next edge may accept a new start.
- Overflow output: nums=16'hFFFF, i.e. all digits non-decimal. The scanner renders these as dashes.
- Input boundaries:
  - bin=0 → nums=16'h0000.
  - bin=MAX_VAL → 16'h9999.
  - bin=MAX_VAL+1 → overflow.
- Reset during SHIFT or DONE:
  - Aborts the conversion and returns to IDLE.
  - nums is cleared to 0 (no partial result is ever output) and done is not pulsed.
  - rst and start on the same edge: rst wins.

Optional Feature:
- Macro: BIN2BCD_LZ_BLANK_EN.
- Defined:
  - Leading-zero suppression is applied when nums is loaded.
  - Going from digit 3 down to digit 1, each zero digit that has only zero digits above it is replaced by 4'hF.
  - Digit 0 is never replaced.
  - Examples: 39 → 16'hFF39; 0 → 16'hFFF0; 1000 → 16'h1000.
  - Overflow output is unchanged (16'hFFFF).
- Not defined:
  - Plain zero-padded BCD, e.g. 39 → 16'h0039.
  - No suppression logic is synthesized.

Test Plan:
- Reset, then start with bin=39 (macro off) → busy for 15 cycles, done pulse at edge N+15, nums=16'h0039, overflow=0. nums=16'h0000 until then.
- bin=9999, then bin=0, then bin=1000 back-to-back with start held high → nums=16'h9999, 16'h0000, 16'h1000 in turn; one done pulse each, each exactly 15 cycles after its accept.
- bin=10000 → done at edge N+2, nums=16'hFFFF, overflow=1. A following bin=5 → nums=16'h0005, overflow=0.
- During a bin=1234 conversion, pulse start with bin=42 at cycle 5 → ignored; result 16'h1234, only one done pulse.
- Assert rst at cycle 8 of a bin=7777 conversion → next cycle busy=0, nums=0, no done pulse. The following start with bin=12 → 16'h0012.
- BIN2BCD_LZ_BLANK_EN defined: bin=39 → 16'hFF39; bin=0 → 16'hFFF0; bin=205 → 16'hF205; bin=10000 → 16'hFFFF.
